// File: rtl/wb_stream_writer.sv
// Wishbone pipelined-mode burst writer.
// Buffers stream words in a small registered FIFO and writes them to consecutive
// word addresses of a Wishbone slave, keeping at most MAX_OUTST requests in flight.
// A burst ends with a one-cycle done pulse once every issued request is acknowledged.
module wb_stream_writer #(
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_OUTST  = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_start,
   input  logic [31:0] i_base_addr,
   input  logic [15:0] i_len,
   input  logic        i_abort,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_words_written
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT  = (PW + 1)'(FIFO_DEPTH);
   localparam logic [3:0]  OUTST_LIM = 4'(MAX_OUTST);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   state_t        state;
   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   fifo_cnt;
   logic [15:0]   len_q;
   logic [15:0]   rx_cnt;
   logic [15:0]   issued;
   logic [15:0]   acked;
   logic [31:0]   addr_q;
   logic [3:0]    outst;
   logic          done_q;

   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          accept;
   logic          ack_ok;

   // Handshake and bus request decode; everything here depends only on registered state
   // so the request stays stable while the slave stalls.
   always_comb begin
      fifo_empty = (fifo_cnt == '0);
      fifo_full  = (fifo_cnt == FULL_CNT);
      s_ready    = (state == RUN) && !fifo_full && (rx_cnt < len_q);
      o_wb_cyc   = (state != IDLE);
      o_wb_stb   = (state == RUN) && !fifo_empty && (outst < OUTST_LIM);
      o_wb_we    = o_wb_stb;
      o_wb_addr  = o_wb_stb ? addr_q : 32'd0;
      o_wb_data  = o_wb_stb ? fifo_mem[rd_ptr] : 32'd0;
      push       = s_valid && s_ready;
      accept     = o_wb_stb && !i_wb_stall;
      ack_ok     = o_wb_cyc && i_wb_ack && (outst != 4'd0);
   end

   assign o_busy          = (state != IDLE);
   assign o_done          = done_q;
   assign o_words_written = acked;

   // FIFO storage: plain registered memory, a pushed word is readable from the next cycle.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= s_data;
      end
   end

   // Burst control FSM together with FIFO pointers, address and request/ack bookkeeping.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         len_q    <= '0;
         rx_cnt   <= '0;
         issued   <= '0;
         acked    <= '0;
         addr_q   <= '0;
         outst    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  len_q    <= i_len;
                  addr_q   <= i_base_addr;
                  rx_cnt   <= '0;
                  issued   <= '0;
                  acked    <= '0;
                  outst    <= '0;
                  wr_ptr   <= '0;
                  rd_ptr   <= '0;
                  fifo_cnt <= '0;
                  if (i_len == 16'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN, WAIT_ACK: begin
               if (i_abort) begin
                  state    <= IDLE;
                  wr_ptr   <= '0;
                  rd_ptr   <= '0;
                  fifo_cnt <= '0;
                  outst    <= '0;
                  if (ack_ok) begin
                     acked <= acked + 16'd1;
                  end
               end else begin
                  if (push) begin
                     wr_ptr <= wr_ptr + 1'b1;
                     rx_cnt <= rx_cnt + 16'd1;
                  end
                  if (accept) begin
                     rd_ptr <= rd_ptr + 1'b1;
                     addr_q <= addr_q + 32'd1;
                     issued <= issued + 16'd1;
                  end
                  case ({push, accept})
                     2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                     2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                     default: fifo_cnt <= fifo_cnt;
                  endcase
                  case ({accept, ack_ok})
                     2'b10:   outst <= outst + 4'd1;
                     2'b01:   outst <= outst - 4'd1;
                     default: outst <= outst;
                  endcase
                  if (ack_ok) begin
                     acked <= acked + 16'd1;
                  end
                  if (state == RUN && accept && (issued + 16'd1 == len_q)) begin
                     state <= WAIT_ACK;
                  end
                  if (state == WAIT_ACK && ack_ok && (acked + 16'd1 == len_q)) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stream_writer.sv
// Self-checking bench for wb_stream_writer: random stream gaps, random slave stalls and
// delayed acks, checked every cycle against a transaction-level model of the burst.
module tb_wb_stream_writer;

   localparam int DEPTH = 8;
   localparam int MAXO  = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        i_start = 1'b0;
   logic [31:0] i_base_addr = 32'd0;
   logic [15:0] i_len = 16'd0;
   logic        i_abort = 1'b0;
   logic [31:0] s_data = 32'd0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic [31:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic        i_wb_ack = 1'b0;
   logic        i_wb_stall = 1'b0;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_words_written;

   wb_stream_writer #(.FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
      .clk(clk), .resetn(resetn), .i_start(i_start), .i_base_addr(i_base_addr),
      .i_len(i_len), .i_abort(i_abort), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .i_wb_ack(i_wb_ack),
      .i_wb_stall(i_wb_stall), .o_busy(o_busy), .o_done(o_done),
      .o_words_written(o_words_written)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Burst-level reference model state
   logic [31:0] src[$];
   logic [31:0] m_base;
   int          m_len = 0;
   bit          m_busy = 0;
   bit          m_done = 0;
   int          m_pushed = 0;
   int          m_issued = 0;
   int          m_acks = 0;

   // Slave and stimulus knobs
   logic [31:0] ram [logic [31:0]];
   int          ack_due[$];
   int          cyc_n = 0;
   int          stall_pct = 0;
   int          gap_pct = 0;
   int          ack_dly = 1;
   bit          hold_valid = 0;
   bit          go_start = 0;
   bit          go_abort = 0;
   bit          extra_ack = 0;
   bit          saw_full = 0;
   bit          prev_stalled = 0;
   logic [31:0] prev_addr;
   logic [31:0] prev_data;
   int          dut_out = 0;
   int          writes = 0;
   int          done_count = 0;
   int          stb_run = 0;
   int          max_stb_run = 0;

   task automatic chk1(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs at negedge, drive inputs, advance model to the next edge.
   task automatic applyStimulus();
      bit exp_ready, exp_stb, push, accept, ackv, ack_cnt, stall;
      int occ;
      @(negedge clk);
      cyc_n++;
      occ       = m_pushed - m_issued;
      exp_ready = m_busy && (occ < DEPTH) && (m_pushed < m_len);
      exp_stb   = m_busy && (occ > 0) && ((m_issued - m_acks) < MAXO);
      chk1("cyc", o_wb_cyc, m_busy);
      chk1("busy", o_busy, m_busy);
      chk1("s_ready", s_ready, exp_ready);
      chk1("stb", o_wb_stb, exp_stb);
      chk1("we", o_wb_we, exp_stb);
      chk1("done", o_done, m_done);
      chk32("words_written", 32'(o_words_written), 32'(m_acks));
      chk1("outst_limit", dut_out <= MAXO, 1'b1);
      if (prev_stalled && exp_stb) begin
         chk32("stall_addr_hold", o_wb_addr, prev_addr);
         chk32("stall_data_hold", o_wb_data, prev_data);
      end
      if (o_done) done_count++;
      if (m_busy && occ == DEPTH && s_ready === 1'b0) saw_full = 1;

      stall = ($urandom_range(99) < stall_pct);
      ackv  = extra_ack;
      if (!ackv && ack_due.size() > 0 && ack_due[0] <= cyc_n) begin
         ackv = 1;
         void'(ack_due.pop_front());
      end
      if (m_pushed < m_len) begin
         s_valid = ($urandom_range(99) >= gap_pct);
         s_data  = src[m_pushed];
      end else begin
         s_valid = hold_valid;
         s_data  = 32'hDEAD_0000 + 32'(cyc_n);
      end
      i_wb_stall = stall;
      i_wb_ack   = ackv;
      i_start    = go_start;
      i_abort    = go_abort;

      push   = s_valid && exp_ready;
      accept = exp_stb && !stall;
      if (accept) begin
         chk32("addr", o_wb_addr, m_base + 32'(m_issued));
         chk32("data", o_wb_data, src[m_issued]);
      end
      if (o_wb_cyc && ackv && dut_out > 0) dut_out--;
      if (o_wb_stb && o_wb_we && !stall) begin
         ram[o_wb_addr] = o_wb_data;
         writes++;
         dut_out++;
         ack_due.push_back(cyc_n + ack_dly);
      end
      if (o_wb_stb) begin
         stb_run++;
         if (stb_run > max_stb_run) max_stb_run = stb_run;
      end else begin
         stb_run = 0;
      end

      ack_cnt = m_busy && ackv && (m_issued > m_acks);
      m_done  = 0;
      if (go_abort && m_busy) begin
         if (ack_cnt) m_acks++;
         m_busy = 0;
      end else if (go_start && !m_busy) begin
         m_pushed = 0;
         m_issued = 0;
         m_acks   = 0;
         if (m_len == 0) m_done = 1;
         else m_busy = 1;
      end else if (m_busy) begin
         if (push) m_pushed++;
         if (accept) m_issued++;
         if (ack_cnt) m_acks++;
         if (m_acks == m_len) begin
            m_busy = 0;
            m_done = 1;
         end
      end
      prev_stalled = o_wb_stb && stall;
      prev_addr    = o_wb_addr;
      prev_data    = o_wb_data;
      @(posedge clk);
      go_start  = 0;
      go_abort  = 0;
      extra_ack = 0;
   endtask

   task automatic startBurst(logic [31:0] base, int len, bit seq, logic [31:0] first);
      src.delete();
      for (int i = 0; i < len; i++) src.push_back(seq ? first + 32'(i) : $urandom);
      ram.delete();
      ack_due.delete();
      m_base      = base;
      m_len       = len;
      i_base_addr = base;
      i_len       = 16'(len);
      dut_out     = 0;
      writes      = 0;
      done_count  = 0;
      max_stb_run = 0;
      stb_run     = 0;
      saw_full    = 0;
      go_start    = 1;
      applyStimulus();
   endtask

   task automatic checkOutput(string tag);
      int n = 0;
      while (m_busy && n < 2000) begin
         applyStimulus();
         n++;
      end
      chk1({tag, "_finished_in_budget"}, m_busy, 1'b0);
      applyStimulus();
      applyStimulus();
      chk32({tag, "_done_pulses"}, 32'(done_count), 32'd1);
      chk32({tag, "_writes"}, 32'(writes), 32'(m_len));
      chk32({tag, "_words_written"}, 32'(o_words_written), 32'(m_len));
      for (int i = 0; i < m_len; i++) begin
         logic [31:0] a;
         a = m_base + 32'(i);
         chk32($sformatf("%s_ram_%08h", tag, a), ram.exists(a) ? ram[a] : 32'hBAD0_BAD0, src[i]);
      end
   endtask

   initial begin
      // Reset state
      #12;
      chk1("rst_cyc", o_wb_cyc, 1'b0);
      chk1("rst_stb", o_wb_stb, 1'b0);
      chk1("rst_ready", s_ready, 1'b0);
      chk1("rst_busy", o_busy, 1'b0);
      chk1("rst_done", o_done, 1'b0);
      chk32("rst_words", 32'(o_words_written), 32'd0);
      chk32("rst_addr", o_wb_addr, 32'd0);
      chk32("rst_data", o_wb_data, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Back-to-back stream into zero-stall, one-cycle-ack RAM
      stall_pct = 0; gap_pct = 0; ack_dly = 1; hold_valid = 0;
      startBurst(32'h100, 8, 1, 32'hA0);
      checkOutput("t1");
      chk32("t1_consecutive_stb", 32'(max_stb_run), 32'd8);
      extra_ack = 1;
      applyStimulus();
      applyStimulus();
      chk32("t1_idle_ack_ignored", 32'(o_words_written), 32'd8);

      // Random stalls, three-cycle ack latency
      stall_pct = 50; ack_dly = 3;
      startBurst($urandom, 6, 0, 32'd0);
      checkOutput("t2");

      // Stream gaps, valid held after the last word, FIFO filled against a stalled slave
      stall_pct = 100; gap_pct = 25; ack_dly = 2; hold_valid = 1;
      startBurst(32'h4000, 20, 0, 32'd0);
      for (int i = 0; i < 20; i++) applyStimulus();
      chk1("t3_fifo_full_blocks_ready", saw_full, 1'b1);
      stall_pct = 20; gap_pct = 40;
      checkOutput("t3");
      hold_valid = 0;

      // Zero-length burst and address wrap
      stall_pct = 20; gap_pct = 10;
      startBurst(32'h55, 0, 0, 32'd0);
      applyStimulus();
      applyStimulus();
      chk32("t4_len0_done_pulses", 32'(done_count), 32'd1);
      startBurst(32'hFFFF_FFFE, 4, 0, 32'd0);
      checkOutput("t4");

      // Abort (with a simultaneous start) after three acks, then a clean burst
      stall_pct = 30; ack_dly = 2;
      startBurst(32'h1000, 10, 0, 32'd0);
      for (int i = 0; i < 200 && m_acks < 3; i++) applyStimulus();
      go_abort = 1;
      go_start = 1;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      chk32("t5_abort_no_done", 32'(done_count), 32'd0);
      chk1("t5_abort_idle", o_busy, 1'b0);
      chk32("t5_abort_words", 32'(o_words_written), 32'(m_acks));
      startBurst(32'h2000, 10, 0, 32'd0);
      checkOutput("t5");

      // Asynchronous reset between clock edges in the middle of a burst
      stall_pct = 60;
      startBurst(32'h3000, 12, 0, 32'd0);
      for (int i = 0; i < 30 && !(m_busy && m_pushed > m_issued); i++) applyStimulus();
      chk1("t6_busy_before_reset", o_busy, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      chk1("t6_cyc_async", o_wb_cyc, 1'b0);
      chk1("t6_stb_async", o_wb_stb, 1'b0);
      chk1("t6_ready_async", s_ready, 1'b0);
      chk1("t6_busy_async", o_busy, 1'b0);
      m_busy = 0; m_done = 0; m_acks = 0; m_pushed = 0; m_issued = 0;
      prev_stalled = 0; dut_out = 0;
      ack_due.delete();
      @(negedge clk);
      i_start = 0; i_abort = 0; i_wb_ack = 0; s_valid = 0;
      resetn = 1'b1;
      stall_pct = 10;
      startBurst(32'h3100, 5, 0, 32'd0);
      checkOutput("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
